// File: rtl/merge_arbiter2x1.sv
// Two-to-one stream merger: one holding register per input, burst-limited
// round-robin or static/priority arbitration into a registered output.
module merge_arbiter2x1 #(
  parameter int SIZE  = 32,
  parameter int BURST = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SIZE-1:0] in1_data,
  input  logic            in1_wr,
  output logic            in1_full,
  input  logic [SIZE-1:0] in2_data,
  input  logic            in2_wr,
  output logic            in2_full,
  output logic [SIZE-1:0] out1_data,
  output logic            out1_wr,
  input  logic            out1_full,
  input  logic [1:0]      mode,
  output logic            sel,
  output logic            err_ovf
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [SIZE-1:0] buf1_data_q, buf1_data_d, buf2_data_q, buf2_data_d;
  logic            buf1_vld_q, buf1_vld_d, buf2_vld_q, buf2_vld_d;
  logic            owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q;
  logic [SIZE-1:0] out_data_q, out_data_d;
  logic            out_wr_q, out_wr_d;
  logic            err_q, err_d;

  logic            e1, e2, own_e, oth_e;
  logic [CW-1:0]   cnt_eff;
  logic            grant, gsel, pop1, pop2, acc1, acc2;

  always_comb begin
    e1      = buf1_vld_q & (mode != 2'd2);
    e2      = buf2_vld_q & (mode != 2'd1);
    // A mode change starts a fresh tenure count for this very decision.
    cnt_eff = (mode != mode_q) ? '0 : cnt_q;
    own_e   = owner_q ? e2 : e1;
    oth_e   = owner_q ? e1 : e2;
    grant   = 1'b0;
    gsel    = owner_q;
    owner_d = owner_q;
    cnt_d   = cnt_eff;

    if (!out1_full) begin
      if (mode == 2'd0) begin
        if (own_e && ((cnt_eff < BURST_C) || !oth_e)) begin
          grant = 1'b1;
          gsel  = owner_q;
          if (cnt_eff < BURST_C) cnt_d = cnt_eff + ONE_C;
        end else if (oth_e) begin
          grant   = 1'b1;
          gsel    = ~owner_q;
          owner_d = ~owner_q;
          cnt_d   = ONE_C;
        end
      end else begin
        // Masking in e1/e2 makes modes 1 and 2 a special case of priority-in1.
        if (e1) begin
          grant = 1'b1;
          gsel  = 1'b0;
        end else if (e2) begin
          grant = 1'b1;
          gsel  = 1'b1;
        end
        if (grant) begin
          owner_d = gsel;
          cnt_d   = ONE_C;
        end
      end
    end

    pop1     = grant & ~gsel;
    pop2     = grant & gsel;
    in1_full = buf1_vld_q & ~pop1;
    in2_full = buf2_vld_q & ~pop2;
    acc1     = in1_wr & ~in1_full;
    acc2     = in2_wr & ~in2_full;

    buf1_vld_d  = acc1 | (buf1_vld_q & ~pop1);
    buf2_vld_d  = acc2 | (buf2_vld_q & ~pop2);
    buf1_data_d = acc1 ? in1_data : buf1_data_q;
    buf2_data_d = acc2 ? in2_data : buf2_data_q;

    out_wr_d   = grant;
    out_data_d = out_data_q;
    if (grant) out_data_d = gsel ? buf2_data_q : buf1_data_q;

    err_d = err_q | (in1_wr & in1_full) | (in2_wr & in2_full);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf1_data_q <= '0;
      buf2_data_q <= '0;
      buf1_vld_q  <= 1'b0;
      buf2_vld_q  <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 2'd0;
      out_data_q  <= '0;
      out_wr_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      buf1_data_q <= buf1_data_d;
      buf2_data_q <= buf2_data_d;
      buf1_vld_q  <= buf1_vld_d;
      buf2_vld_q  <= buf2_vld_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode;
      out_data_q  <= out_data_d;
      out_wr_q    <= out_wr_d;
      err_q       <= err_d;
    end
  end

  assign out1_data = out_data_q;
  assign out1_wr   = out_wr_q;
  assign sel       = owner_q;
  assign err_ovf   = err_q;

endmodule

// File: tb/tb_merge_arbiter2x1.sv
// Bench for merge_arbiter2x1: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_merge_arbiter2x1;

  localparam int SIZE  = 32;
  localparam int BURST = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [SIZE-1:0] in1_data, in2_data, out1_data;
  logic            in1_wr, in2_wr, in1_full, in2_full;
  logic            out1_wr, out1_full, sel, err_ovf;
  logic [1:0]      mode;

  merge_arbiter2x1 #(.SIZE(SIZE), .BURST(BURST)) dut (
    .clock(clock), .reset(reset),
    .in1_data(in1_data), .in1_wr(in1_wr), .in1_full(in1_full),
    .in2_data(in2_data), .in2_wr(in2_wr), .in2_full(in2_full),
    .out1_data(out1_data), .out1_wr(out1_wr), .out1_full(out1_full),
    .mode(mode), .sel(sel), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [SIZE-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in1_wr = 1'b0; in2_wr = 1'b0;
    in1_data = '0; in2_data = '0;
    out1_full = 1'b0; mode = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit rst; bit [1:0] mode; bit ofull;
    bit w1; logic [31:0] d1; bit w2; logic [31:0] d2;
    bit f1; bit f2; bit owr; logic [31:0] odata; bit osel;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit rst, bit [1:0] md, bit of, bit w1, logic [31:0] d1,
                              bit w2, logic [31:0] d2, bit f1, bit f2, bit owr,
                              logic [31:0] od, bit os);
    vec_t v;
    v.rst = rst; v.mode = md; v.ofull = of; v.w1 = w1; v.d1 = d1; v.w2 = w2; v.d2 = d2;
    v.f1 = f1; v.f2 = f2; v.owr = owr; v.odata = od; v.osel = os;
    return v;
  endfunction

  // Reference model state: each input holds at most one beat.
  logic [SIZE-1:0] mq1[$], mq2[$];
  int m_owner, m_run, m_prev_mode;
  bit m_err;
  logic [SIZE-1:0] m_last;

  initial begin
    int k;
    logic [31:0] v1, v2, ev;
    bit a1, a2;

    reset = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    chk("rst_out_wr", out1_wr, 0);
    chk("rst_out_data", out1_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_in1_full", in1_full, 0);
    chk("rst_in2_full", in2_full, 0);

    tbl[0]  = mk(1, 0, 0, 1, 32'hA, 0, 0,     0, 0, 0, 32'h0,  0);
    tbl[1]  = mk(0, 0, 0, 1, 32'hB, 0, 0,     0, 0, 1, 32'hA,  0);
    tbl[2]  = mk(0, 0, 0, 1, 32'hC, 0, 0,     0, 0, 1, 32'hB,  0);
    tbl[3]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 1, 32'hC,  0);
    tbl[4]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 0, 32'hC,  0);
    tbl[5]  = mk(1, 1, 0, 0, 0,     1, 32'h55, 0, 0, 0, 32'h0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0,     0, 0,     0, 1, 0, 32'h0,  0);
    tbl[7]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 1, 32'h55, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 0, 32'h55, 1);
    tbl[9]  = mk(1, 0, 1, 1, 32'h11, 1, 32'h22, 0, 0, 0, 32'h0, 0);
    for (int i = 10; i < 14; i++)
      tbl[i] = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,     0, 0,     0, 1, 1, 32'h11, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 1, 32'h22, 1);
    tbl[16] = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 0, 32'h22, 1);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      mode = tbl[i].mode; out1_full = tbl[i].ofull;
      in1_wr = tbl[i].w1; in1_data = tbl[i].d1;
      in2_wr = tbl[i].w2; in2_data = tbl[i].d2;
      #1;
      chk($sformatf("vec%0d_in1_full", i), in1_full, tbl[i].f1);
      chk($sformatf("vec%0d_in2_full", i), in2_full, tbl[i].f2);
      tick();
      chk($sformatf("vec%0d_out_wr", i), out1_wr, tbl[i].owr);
      chk($sformatf("vec%0d_out_data", i), out1_data, tbl[i].odata);
      chk($sformatf("vec%0d_sel", i), sel, tbl[i].osel);
    end
    chk("vec_err", err_ovf, 0);

    // Burst round-robin with both producers saturating
    do_reset();
    v1 = 1; v2 = 101; k = 0;
    for (int c = 0; c < 20; c++) begin
      in1_data = v1; in2_data = v2;
      #1;
      in1_wr = ~in1_full; in2_wr = ~in2_full;
      a1 = in1_wr; a2 = in2_wr;
      tick();
      if (a1) v1++;
      if (a2) v2++;
      if (out1_wr) begin
        if ((k % (2 * BURST)) < BURST) ev = 1 + BURST * (k / (2 * BURST)) + (k % (2 * BURST));
        else ev = 101 + BURST * (k / (2 * BURST)) + (k % (2 * BURST)) - BURST;
        chk($sformatf("burst_data%0d", k), out1_data, ev);
        chk($sformatf("burst_sel%0d", k), sel, (k / BURST) % 2);
        k++;
      end
    end
    chk("burst_beats", k, 19);
    chk("burst_err", err_ovf, 0);
    idle_inputs();

    // Fixed priority with in2 hammered while full
    do_reset();
    mode = 2'd3;
    in1_wr = 1; in1_data = 32'h1000; in2_wr = 1; in2_data = 32'h77;
    tick();
    for (int i = 0; i < 6; i++) begin
      in1_data = 32'h1001 + i; in2_data = 32'h99;
      #1;
      chk("prio_in2_full", in2_full, 1);
      in1_wr = ~in1_full; in2_wr = 1'b1;
      tick();
      chk("prio_out_wr", out1_wr, 1);
      chk("prio_out_data", out1_data, 32'h1000 + i);
      chk("prio_err", err_ovf, 1);
    end
    in1_wr = 0; in2_wr = 0;
    tick();
    chk("prio_last_in1", out1_data, 32'h1006);
    tick();
    chk("prio_in2_wr", out1_wr, 1);
    chk("prio_in2_data", out1_data, 32'h77);
    chk("prio_in2_sel", sel, 1);
    tick();
    chk("prio_idle", out1_wr, 0);
    chk("prio_err_sticky", err_ovf, 1);
    idle_inputs();

    // Reset asserted mid-burst discards buffered beats
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in1_wr = 1; in1_data = 32'h5 + i; in2_wr = (i == 2); in2_data = 32'h8;
      tick();
    end
    in1_wr = 0; in2_wr = 0; out1_full = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_wr", out1_wr, 0);
    chk("mid_rst_out_data", out1_data, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_full1", in1_full, 0);
    chk("mid_rst_full2", in2_full, 0);
    tick();
    reset = 1'b0; out1_full = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_stale", out1_wr, 0);
    end

    // Randomized run against the reference model
    do_reset();
    mq1.delete(); mq2.delete(); exp_q.delete();
    m_owner = 0; m_run = 0; m_prev_mode = 0; m_err = 0; m_last = '0;
    for (int c = 0; c < 600; c++) begin
      int g, eff;
      bit el1, el2, fe1, fe2;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      out1_full = ($urandom_range(0, 3) == 0);
      in1_wr = ($urandom_range(0, 3) != 0); in1_data = $urandom;
      in2_wr = ($urandom_range(0, 3) != 0); in2_data = $urandom;
      #1;
      eff = (int'(mode) != m_prev_mode) ? 0 : m_run;
      el1 = (mq1.size() != 0) && (mode != 2'd2);
      el2 = (mq2.size() != 0) && (mode != 2'd1);
      g = -1;
      if (!out1_full) begin
        if (mode == 2'd0) begin
          bit own_ok, oth_ok;
          own_ok = (m_owner == 0) ? el1 : el2;
          oth_ok = (m_owner == 0) ? el2 : el1;
          if (own_ok && (eff < BURST || !oth_ok)) g = m_owner;
          else if (oth_ok) g = 1 - m_owner;
        end else begin
          if (el1) g = 0;
          else if (el2) g = 1;
        end
      end
      if (g < 0) m_run = eff;
      else if (mode == 2'd0 && g == m_owner) m_run = (eff < BURST) ? eff + 1 : BURST;
      else begin
        m_run = 1;
        m_owner = g;
      end
      m_prev_mode = int'(mode);
      fe1 = (mq1.size() != 0) && (g != 0);
      fe2 = (mq2.size() != 0) && (g != 1);
      chk("rnd_in1_full", in1_full, fe1);
      chk("rnd_in2_full", in2_full, fe2);
      if (g == 0) exp_q.push_back(mq1.pop_front());
      if (g == 1) exp_q.push_back(mq2.pop_front());
      if (in1_wr && fe1) m_err = 1;
      if (in1_wr && !fe1) mq1.push_back(in1_data);
      if (in2_wr && fe2) m_err = 1;
      if (in2_wr && !fe2) mq2.push_back(in2_data);
      tick();
      chk("rnd_out_wr", out1_wr, (g >= 0));
      chk("rnd_sel", sel, m_owner);
      chk("rnd_err", err_ovf, m_err);
      if (out1_wr) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_beat", 1, 0);
        else begin
          m_last = exp_q.pop_front();
          chk("rnd_out_data", out1_data, m_last);
        end
      end else begin
        chk("rnd_out_hold", out1_data, m_last);
      end
    end
    chk("rnd_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
